pipe_scroller: RTL and testbench
================================

Name: pipe_scroller

Overview:
- Generates pipe and coin geometry for the five-pipe playfield and drives Display_Selector's pipe, coin and coin-control inputs.
- Scrolls each pipe left by SPEED pixels per game tick.
- Recycles a pipe that leaves the playfield to the back of the queue with a new pseudo-random gap height, pulsing shift_Coin on each recycle.
- Counts pipes passed by the bird.

Parameters:
- LEFT, 155, playfield left edge (px)
- PIPE_W, 40, pipe width (px)
- SPACING, 100, pipe-to-pipe pitch (px)
- START_X, 485, initial X_L of pipe 0
- GAP_MIN, 80, minimum gap-top y
- GAP_H, 120, gap height (px)
- COIN_DX, 10, coin left offset inside pipe
- COIN_DY, 50, coin y offset below gap top
- SEED, 16'hACE1, LFSR reset/restart value

Ports:
- clk_100MHz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-step strobe
- q_Initial  in  1  synchronous restart (level)
- run  in  1  scrolling enabled when 1
- SPEED  in  4  pixels per tick, 0..15
- Bird_X_L  in  10  bird left x
- X_Edge_OO_L..X_Edge_O4_L  out  10 each  pipe left x
- X_Edge_OO_R..X_Edge_O4_R  out  10 each  pipe right x
- Y_Edge_00_Top..Y_Edge_04_Top  out  10 each  gap top y
- Y_Edge_00_Bottom..Y_Edge_04_Bottom  out  10 each  gap bottom y
- X_Coin_OO_L..X_Coin_O4_L, X_Coin_OO_R..X_Coin_O4_R  out  10 each  coin x bounds
- Y_Coin_00..Y_Coin_04  out  10 each  coin top y
- shift_Coin  out  1  one-cycle pulse on pipe recycle
- pass_pulse  out  1  one-cycle pulse when a pipe's right edge passes the bird
- score  out  8  pipes passed, saturating at 255

Behaviour:
- State per pipe i: xl[i] (10b), gt[i] (10b). Global state: 16-bit LFSR, score, pulse registers.
- Clock and reset: all state changes on posedge clk_100MHz. rst_n=0 asynchronously loads the restart state.
- Restart state (rst_n=0, or q_Initial=1 on a clock edge):
  - xl[i] = START_X + i*SPACING (485, 585, 685, 785, 885)
  - gt[i] = GAP_MIN + 40 = 120
  - LFSR = SEED, score = 0, shift_Coin = 0, pass_pulse = 0
- Priority: q_Initial beats tick in the same cycle.
- LFSR: Fibonacci, taps 16,14,13,11. Shifts every clock except while in restart.
- Derived outputs, combinational from registers:
  - X_R = xl + PIPE_W - 1
  - Top = gt
  - Bottom = gt + GAP_H
  - Coin L = xl + COIN_DX, Coin R = xl + COIN_DX + 19
  - Coin Y = gt + COIN_DY
- Step condition: tick=1 and run=1 and q_Initial=0. On a step, for each pipe, nx = xl - SPEED:
  - if nx <= LEFT - PIPE_W (115): xl <= nx + 5*SPACING and gt <= GAP_MIN + LFSR[6:0] (range 80..207, bottom max 327). shift_Coin = 1 for exactly the next cycle.
  - else xl <= nx.
  - SPEED=0 leaves xl unchanged; no wrap and no pass can occur.
- Wrap invariants: the 100 px pitch guarantees at most one wrap per step, so shift_Coin is a single pulse. All arithmetic is 10-bit unsigned. Operands never underflow because xl > 115 and SPEED <= 15 before subtraction.
- Pass detection: on a step, a non-wrapping pipe with old X_R >= Bird_X_L and new X_R < Bird_X_L asserts pass_pulse for one cycle and increments score. Score saturates at 255.
- Hold: run=0 freezes all positions. tick is ignored and no pulses are generated.
- Latency: geometry outputs update the cycle after the step edge. Pulses are registered and last one cycle.
- Mid-operation reset: rst_n or q_Initial aborts any pending pulse. Both pulses are 0 in the following cycle.

Test Plan:
- Reset → X_Edge_OO_L=485, X_Edge_O4_L=885, X_Edge_OO_R=524, Y_Edge_00_Top=120, Y_Edge_00_Bottom=240, X_Coin_OO_L=495, Y_Coin_00=170, score=0, pulses 0.
- SPEED=5, run=1, 10 ticks → X_Edge_OO_L=435 and X_Edge_O4_L=835; no shift_Coin.
- Pipe 0 stepped to xl=120, then one tick with SPEED=5 → X_Edge_OO_L=615; Y_Edge_00_Top in 80..207 and equal to 80+LFSR[6:0]; exactly one shift_Coin pulse.
- Bird_X_L=200, SPEED=1, pipe 0 X_R stepping 200→199 → one pass_pulse, score=1. With score preloaded to 255 by repeated passes, a further pass leaves score=255.
- tick with run=0, or with SPEED=0 → all outputs unchanged, no pulses.
- q_Initial and tick asserted in the same cycle mid-game → restart values next cycle, no pulse. rst_n asserted asynchronously between edges → outputs take reset values immediately.

Source files
------------

// File: rtl/pipe_scroller.sv
// pipe_scroller
// Pipe and coin geometry generator for the five-pipe playfield.
// Each game step moves every pipe left by SPEED pixels. A pipe that leaves
// the playfield is moved to the back of the queue and given a new gap
// height from a 16-bit LFSR. The block also counts pipes passed by the bird.
//
// Ports
//   clk_100MHz        system clock
//   rst_n             asynchronous active-low reset (loads the restart state)
//   tick              one-cycle game-step strobe
//   q_Initial         synchronous restart (level), has priority over tick
//   run               scrolling enabled when 1
//   SPEED[3:0]        pixels moved per step
//   Bird_X_L[9:0]     bird left x, used for pass detection
//   X_Edge_O*_L/_R    pipe left/right x
//   Y_Edge_0*_Top     gap top y
//   Y_Edge_0*_Bottom  gap bottom y
//   X_Coin_O*_L/_R    coin left/right x
//   Y_Coin_0*         coin top y
//   shift_Coin        one-cycle pulse after a pipe is recycled
//   pass_pulse        one-cycle pulse after a pipe's right edge passes the bird
//   score[7:0]        pipes passed, saturating at 255
module pipe_scroller #(
    parameter logic [9:0]  LEFT    = 10'd155,
    parameter logic [9:0]  PIPE_W  = 10'd40,
    parameter logic [9:0]  SPACING = 10'd100,
    parameter logic [9:0]  START_X = 10'd485,
    parameter logic [9:0]  GAP_MIN = 10'd80,
    parameter logic [9:0]  GAP_H   = 10'd120,
    parameter logic [9:0]  COIN_DX = 10'd10,
    parameter logic [9:0]  COIN_DY = 10'd50,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       q_Initial,
    input  logic       run,
    input  logic [3:0] SPEED,
    input  logic [9:0] Bird_X_L,

    output logic [9:0] X_Edge_OO_L,
    output logic [9:0] X_Edge_O1_L,
    output logic [9:0] X_Edge_O2_L,
    output logic [9:0] X_Edge_O3_L,
    output logic [9:0] X_Edge_O4_L,
    output logic [9:0] X_Edge_OO_R,
    output logic [9:0] X_Edge_O1_R,
    output logic [9:0] X_Edge_O2_R,
    output logic [9:0] X_Edge_O3_R,
    output logic [9:0] X_Edge_O4_R,

    output logic [9:0] Y_Edge_00_Top,
    output logic [9:0] Y_Edge_01_Top,
    output logic [9:0] Y_Edge_02_Top,
    output logic [9:0] Y_Edge_03_Top,
    output logic [9:0] Y_Edge_04_Top,
    output logic [9:0] Y_Edge_00_Bottom,
    output logic [9:0] Y_Edge_01_Bottom,
    output logic [9:0] Y_Edge_02_Bottom,
    output logic [9:0] Y_Edge_03_Bottom,
    output logic [9:0] Y_Edge_04_Bottom,

    output logic [9:0] X_Coin_OO_L,
    output logic [9:0] X_Coin_O1_L,
    output logic [9:0] X_Coin_O2_L,
    output logic [9:0] X_Coin_O3_L,
    output logic [9:0] X_Coin_O4_L,
    output logic [9:0] X_Coin_OO_R,
    output logic [9:0] X_Coin_O1_R,
    output logic [9:0] X_Coin_O2_R,
    output logic [9:0] X_Coin_O3_R,
    output logic [9:0] X_Coin_O4_R,

    output logic [9:0] Y_Coin_00,
    output logic [9:0] Y_Coin_01,
    output logic [9:0] Y_Coin_02,
    output logic [9:0] Y_Coin_03,
    output logic [9:0] Y_Coin_04,

    output logic       shift_Coin,
    output logic       pass_pulse,
    output logic [7:0] score
);

    localparam int unsigned NPIPE = 5;

    // A pipe whose left edge reaches this x has fully left the playfield.
    localparam logic [9:0] WRAP_X  = LEFT - PIPE_W;
    // Distance added on recycle: the length of the whole five-pipe queue.
    localparam logic [9:0] RING    = 10'(NPIPE * SPACING);
    localparam logic [9:0] GAP_RST = GAP_MIN + 10'd40;
    localparam logic [9:0] COIN_W1 = 10'd19;

    logic [9:0]  xl [NPIPE];
    logic [9:0]  gt [NPIPE];
    logic [15:0] lfsr;

    logic [9:0]  nx       [NPIPE];
    logic [9:0]  xr_cur   [NPIPE];
    logic [9:0]  xr_nxt   [NPIPE];
    logic [9:0]  bot      [NPIPE];
    logic [9:0]  coin_l   [NPIPE];
    logic [9:0]  coin_r   [NPIPE];
    logic [9:0]  coin_y   [NPIPE];
    logic [NPIPE-1:0] wrap;
    logic [NPIPE-1:0] pass;
    logic        step;
    logic        lfsr_fb;

    assign step    = tick & run & ~q_Initial;
    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        for (int unsigned i = 0; i < NPIPE; i++) begin
            nx[i]     = xl[i] - {6'd0, SPEED};
            xr_cur[i] = xl[i] + PIPE_W - 10'd1;
            xr_nxt[i] = nx[i] + PIPE_W - 10'd1;
            bot[i]    = gt[i] + GAP_H;
            coin_l[i] = xl[i] + COIN_DX;
            coin_r[i] = xl[i] + COIN_DX + COIN_W1;
            coin_y[i] = gt[i] + COIN_DY;
            wrap[i]   = (nx[i] <= WRAP_X);
            // A recycled pipe jumps to the back, so it can never count as passed.
            pass[i]   = ~wrap[i] && (xr_cur[i] >= Bird_X_L) && (xr_nxt[i] < Bird_X_L);
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NPIPE; i++) begin
                xl[i] <= START_X + 10'(i * SPACING);
                gt[i] <= GAP_RST;
            end
            lfsr       <= SEED;
            score      <= '0;
            shift_Coin <= 1'b0;
            pass_pulse <= 1'b0;
        end else if (q_Initial) begin
            for (int unsigned i = 0; i < NPIPE; i++) begin
                xl[i] <= START_X + 10'(i * SPACING);
                gt[i] <= GAP_RST;
            end
            lfsr       <= SEED;
            score      <= '0;
            shift_Coin <= 1'b0;
            pass_pulse <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr_fb};
            shift_Coin <= 1'b0;
            pass_pulse <= 1'b0;
            if (step) begin
                for (int unsigned i = 0; i < NPIPE; i++) begin
                    if (wrap[i]) begin
                        xl[i] <= nx[i] + RING;
                        gt[i] <= GAP_MIN + {3'd0, lfsr[6:0]};
                    end else begin
                        xl[i] <= nx[i];
                    end
                end
                // The pitch allows at most one wrap and one pass per step.
                shift_Coin <= |wrap;
                pass_pulse <= |pass;
                if ((|pass) && (score != 8'hFF))
                    score <= score + 8'd1;
            end
        end
    end

    assign X_Edge_OO_L      = xl[0];
    assign X_Edge_O1_L      = xl[1];
    assign X_Edge_O2_L      = xl[2];
    assign X_Edge_O3_L      = xl[3];
    assign X_Edge_O4_L      = xl[4];
    assign X_Edge_OO_R      = xr_cur[0];
    assign X_Edge_O1_R      = xr_cur[1];
    assign X_Edge_O2_R      = xr_cur[2];
    assign X_Edge_O3_R      = xr_cur[3];
    assign X_Edge_O4_R      = xr_cur[4];

    assign Y_Edge_00_Top    = gt[0];
    assign Y_Edge_01_Top    = gt[1];
    assign Y_Edge_02_Top    = gt[2];
    assign Y_Edge_03_Top    = gt[3];
    assign Y_Edge_04_Top    = gt[4];
    assign Y_Edge_00_Bottom = bot[0];
    assign Y_Edge_01_Bottom = bot[1];
    assign Y_Edge_02_Bottom = bot[2];
    assign Y_Edge_03_Bottom = bot[3];
    assign Y_Edge_04_Bottom = bot[4];

    assign X_Coin_OO_L      = coin_l[0];
    assign X_Coin_O1_L      = coin_l[1];
    assign X_Coin_O2_L      = coin_l[2];
    assign X_Coin_O3_L      = coin_l[3];
    assign X_Coin_O4_L      = coin_l[4];
    assign X_Coin_OO_R      = coin_r[0];
    assign X_Coin_O1_R      = coin_r[1];
    assign X_Coin_O2_R      = coin_r[2];
    assign X_Coin_O3_R      = coin_r[3];
    assign X_Coin_O4_R      = coin_r[4];

    assign Y_Coin_00        = coin_y[0];
    assign Y_Coin_01        = coin_y[1];
    assign Y_Coin_02        = coin_y[2];
    assign Y_Coin_03        = coin_y[3];
    assign Y_Coin_04        = coin_y[4];

endmodule

// File: tb/tb_pipe_scroller.sv
module tb_pipe_scroller;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       q_Initial;
    logic       run;
    logic [3:0] SPEED;
    logic [9:0] Bird_X_L;

    logic [9:0] d_xl [5];
    logic [9:0] d_xr [5];
    logic [9:0] d_top [5];
    logic [9:0] d_bot [5];
    logic [9:0] d_cl [5];
    logic [9:0] d_cr [5];
    logic [9:0] d_cy [5];
    logic       shift_Coin;
    logic       pass_pulse;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: plain integers, one entry per pipe.
    int m_xl [5];
    int m_gt [5];
    int m_lfsr;
    int m_score;
    int m_shift;
    int m_pass;

    always #5 clk_100MHz = ~clk_100MHz;

    pipe_scroller dut (
        .clk_100MHz(clk_100MHz), .rst_n(rst_n), .tick(tick), .q_Initial(q_Initial),
        .run(run), .SPEED(SPEED), .Bird_X_L(Bird_X_L),
        .X_Edge_OO_L(d_xl[0]), .X_Edge_O1_L(d_xl[1]), .X_Edge_O2_L(d_xl[2]),
        .X_Edge_O3_L(d_xl[3]), .X_Edge_O4_L(d_xl[4]),
        .X_Edge_OO_R(d_xr[0]), .X_Edge_O1_R(d_xr[1]), .X_Edge_O2_R(d_xr[2]),
        .X_Edge_O3_R(d_xr[3]), .X_Edge_O4_R(d_xr[4]),
        .Y_Edge_00_Top(d_top[0]), .Y_Edge_01_Top(d_top[1]), .Y_Edge_02_Top(d_top[2]),
        .Y_Edge_03_Top(d_top[3]), .Y_Edge_04_Top(d_top[4]),
        .Y_Edge_00_Bottom(d_bot[0]), .Y_Edge_01_Bottom(d_bot[1]), .Y_Edge_02_Bottom(d_bot[2]),
        .Y_Edge_03_Bottom(d_bot[3]), .Y_Edge_04_Bottom(d_bot[4]),
        .X_Coin_OO_L(d_cl[0]), .X_Coin_O1_L(d_cl[1]), .X_Coin_O2_L(d_cl[2]),
        .X_Coin_O3_L(d_cl[3]), .X_Coin_O4_L(d_cl[4]),
        .X_Coin_OO_R(d_cr[0]), .X_Coin_O1_R(d_cr[1]), .X_Coin_O2_R(d_cr[2]),
        .X_Coin_O3_R(d_cr[3]), .X_Coin_O4_R(d_cr[4]),
        .Y_Coin_00(d_cy[0]), .Y_Coin_01(d_cy[1]), .Y_Coin_02(d_cy[2]),
        .Y_Coin_03(d_cy[3]), .Y_Coin_04(d_cy[4]),
        .shift_Coin(shift_Coin), .pass_pulse(pass_pulse), .score(score)
    );

    task automatic model_restart();
        for (int i = 0; i < 5; i++) begin
            m_xl[i] = 485 + 100 * i;
            m_gt[i] = 120;
        end
        m_lfsr  = 'hACE1;
        m_score = 0;
        m_shift = 0;
        m_pass  = 0;
    endtask

    // One clock edge of the game rules, applied to the reference state.
    task automatic model_edge();
        int nx;
        int fb;
        if (!rst_n || q_Initial) begin
            model_restart();
            return;
        end
        m_shift = 0;
        m_pass  = 0;
        if (tick && run) begin
            for (int i = 0; i < 5; i++) begin
                nx = m_xl[i] - int'(SPEED);
                if (nx <= 155 - 40) begin
                    m_xl[i] = nx + 500;
                    m_gt[i] = 80 + (m_lfsr % 128);
                    m_shift = 1;
                end else begin
                    if ((m_xl[i] + 39 >= int'(Bird_X_L)) && (nx + 39 < int'(Bird_X_L)))
                        m_pass = 1;
                    m_xl[i] = nx;
                end
            end
            if (m_pass == 1 && m_score < 255)
                m_score = m_score + 1;
        end
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    endtask

    function automatic logic [359:0] exp_vec();
        logic [359:0] v = '0;
        for (int i = 0; i < 5; i++)
            v[i*70 +: 70] = {10'(m_xl[i]), 10'(m_xl[i] + 39), 10'(m_gt[i]), 10'(m_gt[i] + 120),
                             10'(m_xl[i] + 10), 10'(m_xl[i] + 29), 10'(m_gt[i] + 50)};
        v[350]     = m_shift[0];
        v[351]     = m_pass[0];
        v[359:352] = 8'(m_score);
        return v;
    endfunction

    function automatic logic [359:0] dut_vec();
        logic [359:0] v = '0;
        for (int i = 0; i < 5; i++)
            v[i*70 +: 70] = {d_xl[i], d_xr[i], d_top[i], d_bot[i], d_cl[i], d_cr[i], d_cy[i]};
        v[350]     = shift_Coin;
        v[351]     = pass_pulse;
        v[359:352] = score;
        return v;
    endfunction

    // Advance one clock; returns 1 ns after the edge, away from it.
    task automatic cycle();
        @(posedge clk_100MHz);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; q_Initial = 1'b0; run = 1'b0;
        SPEED = 4'd0; Bird_X_L = 10'd0;
        model_restart();
        cycle(); cycle();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
        end
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if (d_xl[0] !== 10'd485) begin n_err++; $display("FAIL reset_xl0: got %0d expected 485", d_xl[0]); end
        n_vec++;
        if (d_xl[4] !== 10'd885) begin n_err++; $display("FAIL reset_xl4: got %0d expected 885", d_xl[4]); end
        n_vec++;
        if (d_xr[0] !== 10'd524) begin n_err++; $display("FAIL reset_xr0: got %0d expected 524", d_xr[0]); end
        n_vec++;
        if (d_top[0] !== 10'd120) begin n_err++; $display("FAIL reset_top0: got %0d expected 120", d_top[0]); end
        n_vec++;
        if (d_bot[0] !== 10'd240) begin n_err++; $display("FAIL reset_bot0: got %0d expected 240", d_bot[0]); end
        n_vec++;
        if (d_cl[0] !== 10'd495) begin n_err++; $display("FAIL reset_coinl0: got %0d expected 495", d_cl[0]); end
        n_vec++;
        if (d_cy[0] !== 10'd170) begin n_err++; $display("FAIL reset_coiny0: got %0d expected 170", d_cy[0]); end
        n_vec++;
        if ({score, shift_Coin, pass_pulse} !== 10'd0) begin
            n_err++; $display("FAIL reset_score_pulses: got %h expected 0", {score, shift_Coin, pass_pulse});
        end
    endtask

    task automatic test_scroll();
        int shifts = 0;
        run = 1'b1; SPEED = 4'd5; Bird_X_L = 10'd0;
        for (int k = 0; k < 10; k++) begin
            tick = 1'b1; cycle(); shifts += int'(shift_Coin);
            tick = 1'b0; cycle(); shifts += int'(shift_Coin);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL scroll_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (d_xl[0] !== 10'd435) begin n_err++; $display("FAIL scroll_xl0: got %0d expected 435", d_xl[0]); end
        n_vec++;
        if (d_xl[4] !== 10'd835) begin n_err++; $display("FAIL scroll_xl4: got %0d expected 835", d_xl[4]); end
        n_vec++;
        if (shifts != 0) begin n_err++; $display("FAIL scroll_no_shift: got %0d expected 0", shifts); end
    endtask

    task automatic test_wrap();
        int shifts = 0;
        int exp_top;
        SPEED = 4'd5; tick = 1'b1;
        repeat (63) begin
            cycle(); shifts += int'(shift_Coin);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL wrap_approach_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (d_xl[0] !== 10'd120) begin n_err++; $display("FAIL wrap_pre_xl0: got %0d expected 120", d_xl[0]); end
        exp_top = 80 + (m_lfsr % 128);
        cycle(); shifts += int'(shift_Coin);
        tick = 1'b0;
        n_vec++;
        if (d_xl[0] !== 10'd615) begin n_err++; $display("FAIL wrap_xl0: got %0d expected 615", d_xl[0]); end
        n_vec++;
        if (d_top[0] !== 10'(exp_top)) begin n_err++; $display("FAIL wrap_top0: got %0d expected %0d", d_top[0], exp_top); end
        n_vec++;
        if (shift_Coin !== 1'b1) begin n_err++; $display("FAIL wrap_shift: got %b expected 1", shift_Coin); end
        repeat (3) begin cycle(); shifts += int'(shift_Coin); end
        n_vec++;
        if (shifts != 1) begin n_err++; $display("FAIL wrap_shift_count: got %0d expected 1", shifts); end
    endtask

    task automatic test_pass();
        int guard;
        q_Initial = 1'b1; tick = 1'b0; cycle(); q_Initial = 1'b0;
        run = 1'b1; Bird_X_L = 10'd200; SPEED = 4'd12; tick = 1'b1;
        repeat (27) cycle();
        n_vec++;
        if (d_xr[0] !== 10'd200 || score !== 8'd0) begin
            n_err++; $display("FAIL pass_pre: got xr=%0d score=%0d expected xr=200 score=0", d_xr[0], score);
        end
        SPEED = 4'd1;
        cycle();
        n_vec++;
        if (d_xr[0] !== 10'd199 || pass_pulse !== 1'b1 || score !== 8'd1) begin
            n_err++; $display("FAIL pass_first: got xr=%0d pass=%b score=%0d expected 199 1 1",
                              d_xr[0], pass_pulse, score);
        end
        guard = 0;
        while (m_score < 255 && guard < 20000) begin
            SPEED = 4'($urandom_range(1, 15));
            cycle(); guard++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL pass_run_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (m_score != 255) begin n_err++; $display("FAIL pass_sat_timeout: got %0d expected 255", m_score); end
        guard = 0;
        do begin
            SPEED = 4'($urandom_range(1, 15));
            cycle(); guard++;
        end while (m_pass == 0 && guard < 200);
        n_vec++;
        if (pass_pulse !== 1'b1 || score !== 8'd255) begin
            n_err++; $display("FAIL pass_saturate: got pass=%b score=%0d expected 1 255", pass_pulse, score);
        end
        tick = 1'b0;
    endtask

    task automatic test_hold();
        logic [359:0] snap;
        cycle();
        snap = exp_vec();
        run = 1'b0;
        repeat (20) begin
            tick = 1'($urandom); SPEED = 4'($urandom);
            cycle();
            n_vec++;
            if (dut_vec() !== {snap[359:352], 2'b00, snap[349:0]}) begin
                n_err++; $display("FAIL hold_run0: got %h expected %h", dut_vec(), {snap[359:352], 2'b00, snap[349:0]});
            end
        end
        run = 1'b1; SPEED = 4'd0; tick = 1'b1;
        repeat (10) begin
            cycle();
            n_vec++;
            if (dut_vec() !== {snap[359:352], 2'b00, snap[349:0]}) begin
                n_err++; $display("FAIL hold_speed0: got %h expected %h", dut_vec(), {snap[359:352], 2'b00, snap[349:0]});
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_restart_collision();
        int guard = 0;
        bit would_wrap = 0;
        run = 1'b1; SPEED = 4'd15; Bird_X_L = 10'd300; tick = 1'b1;
        while (!would_wrap && guard < 200) begin
            cycle(); guard++;
            for (int i = 0; i < 5; i++)
                if (m_xl[i] - 15 <= 115) would_wrap = 1;
        end
        n_vec++;
        if (!would_wrap) begin n_err++; $display("FAIL restart_setup_timeout: got 0 expected 1"); end
        q_Initial = 1'b1;
        cycle();
        q_Initial = 1'b0; tick = 1'b0;
        n_vec++;
        if (d_xl[0] !== 10'd485 || d_xl[4] !== 10'd885 || d_top[0] !== 10'd120 ||
            shift_Coin !== 1'b0 || pass_pulse !== 1'b0 || score !== 8'd0) begin
            n_err++; $display("FAIL restart_priority: got xl0=%0d xl4=%0d top0=%0d sh=%b pp=%b sc=%0d expected 485 885 120 0 0 0",
                              d_xl[0], d_xl[4], d_top[0], shift_Coin, pass_pulse, score);
        end
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL restart_vec: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        run = 1'b1; Bird_X_L = 10'd400;
        repeat (40) begin
            tick = 1'b1; SPEED = 4'($urandom_range(5, 15));
            cycle();
        end
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL async_pre_vec: got %h expected %h", dut_vec(), exp_vec());
        end
        #3 rst_n = 1'b0;
        model_restart();
        #1;
        n_vec++;
        if (d_xl[0] !== 10'd485 || d_top[0] !== 10'd120 || score !== 8'd0 ||
            shift_Coin !== 1'b0 || pass_pulse !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got xl0=%0d top0=%0d sc=%0d sh=%b pp=%b expected 485 120 0 0 0",
                              d_xl[0], d_top[0], score, shift_Coin, pass_pulse);
        end
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL async_reset_vec: got %h expected %h", dut_vec(), exp_vec());
        end
        cycle();
        rst_n = 1'b1; tick = 1'b0;
    endtask

    task automatic test_random();
        repeat (800) begin
            run       = ($urandom_range(0, 7) != 0);
            tick      = 1'($urandom);
            SPEED     = 4'($urandom);
            Bird_X_L  = 10'($urandom_range(120, 700));
            q_Initial = ($urandom_range(0, 99) == 0);
            cycle();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        q_Initial = 1'b0; tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_wrap();
        test_pass();
        test_hold();
        test_restart_collision();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
